// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - two-read/one-write register file with bypass, zero register and busy scoreboard
module reg_file_2r1w #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_port_1,
  input  logic                  read_port_2,
  input  logic [ADDR_WIDTH-1:0] addr_port_1,
  input  logic [ADDR_WIDTH-1:0] addr_port_2,
  input  logic                  write_port,
  input  logic [ADDR_WIDTH-1:0] addr_port_write,
  input  logic [WIDTH-1:0]      din_port_write,
  input  logic                  reserve_en,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  output logic [WIDTH-1:0]      dout_port_1,
  output logic [WIDTH-1:0]      dout_port_2,
  output logic                  rd_valid_1,
  output logic                  rd_valid_2,
  output logic                  busy_1,
  output logic                  busy_2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  logic             wr_eff;
  logic             res_eff;
  logic             zero_1;
  logic             zero_2;
  logic [WIDTH-1:0] rd_data_1;
  logic [WIDTH-1:0] rd_data_2;

  // Register 0 is hardwired when ZERO_REG is set: writes/reserves to it are dropped
  always_comb begin
    wr_eff  = write_port && !((ZERO_REG != 0) && (addr_port_write == '0));
    res_eff = reserve_en && !((ZERO_REG != 0) && (reserve_addr == '0));
    zero_1  = (ZERO_REG != 0) && (addr_port_1 == '0);
    zero_2  = (ZERO_REG != 0) && (addr_port_2 == '0);
  end

  // Post-edge busy vector: a write clears, a same-cycle reserve (newer producer) wins
  always_comb begin
    busy_next = busy;
    if (wr_eff) begin
      busy_next[addr_port_write] = 1'b0;
    end
    if (res_eff) begin
      busy_next[reserve_addr] = 1'b1;
    end
  end

  // Read muxes with write-to-read bypass so a same-cycle write is never missed
  always_comb begin
    rd_data_1 = mem[addr_port_1];
    rd_data_2 = mem[addr_port_2];
    if (wr_eff && (addr_port_write == addr_port_1)) begin
      rd_data_1 = din_port_write;
    end
    if (wr_eff && (addr_port_write == addr_port_2)) begin
      rd_data_2 = din_port_write;
    end
    if (zero_1) begin
      rd_data_1 = '0;
    end
    if (zero_2) begin
      rd_data_2 = '0;
    end
  end

  // Storage array and busy scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_eff) begin
        mem[addr_port_write] <= din_port_write;
      end
      busy <= busy_next;
    end
  end

  // Port 1 output registers: capture on read, hold otherwise, valid pulses for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_port_1 <= '0;
      busy_1      <= 1'b0;
      rd_valid_1  <= 1'b0;
    end else begin
      rd_valid_1 <= read_port_1;
      if (read_port_1) begin
        dout_port_1 <= rd_data_1;
        busy_1      <= busy_next[addr_port_1] && !zero_1;
      end
    end
  end

  // Port 2 output registers: capture on read, hold otherwise, valid pulses for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_port_2 <= '0;
      busy_2      <= 1'b0;
      rd_valid_2  <= 1'b0;
    end else begin
      rd_valid_2 <= read_port_2;
      if (read_port_2) begin
        dout_port_2 <= rd_data_2;
        busy_2      <= busy_next[addr_port_2] && !zero_2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - directed scoreboard testbench for reg_file_2r1w
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_port_1, read_port_2;
  logic [3:0]  addr_port_1, addr_port_2;
  logic        write_port;
  logic [3:0]  addr_port_write;
  logic [31:0] din_port_write;
  logic        reserve_en;
  logic [3:0]  reserve_addr;

  logic [31:0] dout_port_1, dout_port_2;
  logic        rd_valid_1, rd_valid_2, busy_1, busy_2;
  logic [31:0] z0_dout_port_1, z0_dout_port_2;
  logic        z0_rd_valid_1, z0_rd_valid_2, z0_busy_1, z0_busy_2;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  localparam int S_D1 = 0, S_D2 = 1, S_V1 = 2, S_V2 = 3, S_B1 = 4, S_B2 = 5,
                 S_Z0_D1 = 6, S_Z0_B1 = 7;

  always #5 clk = ~clk;

  reg_file_2r1w #(.ADDR_WIDTH(4), .WIDTH(32), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .read_port_1(read_port_1), .read_port_2(read_port_2),
    .addr_port_1(addr_port_1), .addr_port_2(addr_port_2),
    .write_port(write_port), .addr_port_write(addr_port_write),
    .din_port_write(din_port_write),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .dout_port_1(dout_port_1), .dout_port_2(dout_port_2),
    .rd_valid_1(rd_valid_1), .rd_valid_2(rd_valid_2),
    .busy_1(busy_1), .busy_2(busy_2)
  );

  reg_file_2r1w #(.ADDR_WIDTH(4), .WIDTH(32), .ZERO_REG(0)) u_dut_z0 (
    .clk(clk), .rst_n(rst_n),
    .read_port_1(read_port_1), .read_port_2(read_port_2),
    .addr_port_1(addr_port_1), .addr_port_2(addr_port_2),
    .write_port(write_port), .addr_port_write(addr_port_write),
    .din_port_write(din_port_write),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .dout_port_1(z0_dout_port_1), .dout_port_2(z0_dout_port_2),
    .rd_valid_1(z0_rd_valid_1), .rd_valid_2(z0_rd_valid_2),
    .busy_1(z0_busy_1), .busy_2(z0_busy_2)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_D1:    return dout_port_1;
      S_D2:    return dout_port_2;
      S_V1:    return {31'd0, rd_valid_1};
      S_V2:    return {31'd0, rd_valid_2};
      S_B1:    return {31'd0, busy_1};
      S_B2:    return {31'd0, busy_2};
      S_Z0_D1: return z0_dout_port_1;
      default: return {31'd0, z0_busy_1};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle();
    read_port_1 = 1'b0; read_port_2 = 1'b0;
    write_port  = 1'b0; reserve_en  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    addr_port_1 = 4'd0; addr_port_2 = 4'd0;
    addr_port_write = 4'd0; din_port_write = 32'd0; reserve_addr = 4'd0;

    // Inputs during reset must be ignored
    read_port_1 = 1'b1; write_port = 1'b1; addr_port_write = 4'd5; din_port_write = 32'hCAFE_0001;
    repeat (2) @(posedge clk);
    #1;
    push("rst_d1", S_D1, 32'd0); push("rst_d2", S_D2, 32'd0);
    push("rst_v1", S_V1, 32'd0); push("rst_v2", S_V2, 32'd0);
    push("rst_b1", S_B1, 32'd0); push("rst_b2", S_B2, 32'd0);
    drain();

    // Reset then read addr 5 on both ports
    rst_n = 1'b1;
    idle();
    read_port_1 = 1'b1; read_port_2 = 1'b1; addr_port_1 = 4'd5; addr_port_2 = 4'd5;
    push("r5_d1", S_D1, 32'd0); push("r5_d2", S_D2, 32'd0);
    push("r5_v1", S_V1, 32'd1); push("r5_v2", S_V2, 32'd1);
    push("r5_b1", S_B1, 32'd0); push("r5_b2", S_B2, 32'd0);
    step();

    // Write then read
    idle();
    write_port = 1'b1; addr_port_write = 4'd3; din_port_write = 32'hDEAD_BEEF;
    push("wr_v1", S_V1, 32'd0); push("wr_v2", S_V2, 32'd0);
    step();
    idle();
    read_port_1 = 1'b1; addr_port_1 = 4'd3; read_port_2 = 1'b1; addr_port_2 = 4'd4;
    push("rd3_d1", S_D1, 32'hDEAD_BEEF); push("rd4_d2", S_D2, 32'd0);
    step();

    // Bypass: addr 7 holds DEADBEEF, then a same-cycle write+read must return new data
    idle();
    write_port = 1'b1; addr_port_write = 4'd7; din_port_write = 32'hDEAD_BEEF;
    step();
    read_port_1 = 1'b1; read_port_2 = 1'b1; addr_port_1 = 4'd7; addr_port_2 = 4'd7;
    din_port_write = 32'h1234_5678;
    push("byp_d1", S_D1, 32'h1234_5678); push("byp_d2", S_D2, 32'h1234_5678);
    step();

    // Zero register: write, reserve and read addr 0 in one cycle, then read again
    idle();
    write_port = 1'b1; addr_port_write = 4'd0; din_port_write = 32'hFFFF_FFFF;
    reserve_en = 1'b1; reserve_addr = 4'd0;
    read_port_1 = 1'b1; addr_port_1 = 4'd0;
    push("zr_byp_d1", S_D1, 32'd0); push("zr_byp_b1", S_B1, 32'd0);
    push("z0_byp_d1", S_Z0_D1, 32'hFFFF_FFFF); push("z0_byp_b1", S_Z0_B1, 32'd1);
    step();
    idle();
    read_port_1 = 1'b1; addr_port_1 = 4'd0;
    push("zr_d1", S_D1, 32'd0); push("zr_b1", S_B1, 32'd0);
    push("z0_d1", S_Z0_D1, 32'hFFFF_FFFF); push("z0_b1", S_Z0_B1, 32'd1);
    step();

    // Scoreboard: reserve 9, then read busy
    idle();
    reserve_en = 1'b1; reserve_addr = 4'd9;
    step();
    idle();
    read_port_1 = 1'b1; addr_port_1 = 4'd9;
    push("res9_b1", S_B1, 32'd1);
    step();

    // Write 9 clears busy
    idle();
    write_port = 1'b1; addr_port_write = 4'd9; din_port_write = 32'h0000_A5A5;
    step();
    idle();
    read_port_1 = 1'b1; addr_port_1 = 4'd9;
    push("wr9_b1", S_B1, 32'd0); push("wr9_d1", S_D1, 32'h0000_A5A5);
    step();

    // Reserve and write 9 together: reserve wins, data still updated
    idle();
    write_port = 1'b1; addr_port_write = 4'd9; din_port_write = 32'h0000_5A5A;
    reserve_en = 1'b1; reserve_addr = 4'd9;
    read_port_2 = 1'b1; addr_port_2 = 4'd9;
    push("rw9_byp_b2", S_B2, 32'd1); push("rw9_byp_d2", S_D2, 32'h0000_5A5A);
    step();
    idle();
    read_port_1 = 1'b1; addr_port_1 = 4'd9;
    push("rw9_b1", S_B1, 32'd1); push("rw9_d1", S_D1, 32'h0000_5A5A);
    step();

    // Hold: drop read_port_1 with a different address presented
    idle();
    addr_port_1 = 4'd3;
    push("hold_v1", S_V1, 32'd0); push("hold_d1", S_D1, 32'h0000_5A5A);
    push("hold_b1", S_B1, 32'd1);
    step();

    // Async reset pulse between edges
    idle();
    read_port_1 = 1'b1; addr_port_1 = 4'd3; read_port_2 = 1'b1; addr_port_2 = 4'd9;
    step();
    #2 rst_n = 1'b0;
    #1;
    push("arst_d1", S_D1, 32'd0); push("arst_d2", S_D2, 32'd0);
    push("arst_v1", S_V1, 32'd0); push("arst_v2", S_V2, 32'd0);
    push("arst_b1", S_B1, 32'd0); push("arst_b2", S_B2, 32'd0);
    drain();
    #1 rst_n = 1'b1;
    push("post_d1", S_D1, 32'd0); push("post_v1", S_V1, 32'd1);
    push("post_b2", S_B2, 32'd0); push("post_v2", S_V2, 32'd1);
    step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
